memory_mb_arbiter: RTL and testbench

Single-clock request arbiter and sequencer for the multi-bank dual-port memory array. It accepts independent read/write requests from `num_req` requesters against a flat, low-order bank-interleaved address space. Each cycle it grants at most one write and one read per bank, using separate round-robin arbiters per bank and per port. It drives registered bank commands into the memory banks and returns read data to the issuing requester at a fixed latency.

---
 rtl/memory_mb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_memory_mb_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_mb_arbiter.sv
// Multi-bank request arbiter/sequencer: per-bank, per-port round-robin grants,
// a registered bank command stage and a fixed 3-cycle read response path.
module memory_mb_arbiter #(
    parameter int bit_width        = 32,
    parameter int num_banks        = 4,
    parameter int num_bank_entries = 64,
    parameter int num_req          = 4,
    localparam int bank_bits       = $clog2(num_banks),
    localparam int row_bits        = $clog2(num_bank_entries),
    localparam int addr_bit_width  = bank_bits + row_bits,
    localparam int id_bits         = $clog2(num_req)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [num_req-1:0]                       req_valid,
    input  logic [num_req-1:0]                       req_we,
    input  logic [num_req-1:0][addr_bit_width-1:0]   req_addr,
    input  logic [num_req-1:0][bit_width-1:0]        req_wdata,
    output logic [num_req-1:0]                       req_ready,
    output logic [num_req-1:0]                       rsp_valid,
    output logic [num_req-1:0][bit_width-1:0]        rsp_data,
    output logic [num_banks-1:0]                     mem_wr_en,
    output logic [num_banks-1:0][row_bits-1:0]       mem_wr_addr,
    output logic [num_banks-1:0][bit_width-1:0]      mem_wr_data,
    output logic [num_banks-1:0]                     mem_rd_en,
    output logic [num_banks-1:0][row_bits-1:0]       mem_rd_addr,
    input  logic [num_banks-1:0][bit_width-1:0]      mem_rd_data
);

    function automatic logic [id_bits-1:0] rr_idx(input logic [id_bits-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= num_req) s = s - num_req;
        return id_bits'(s);
    endfunction

    function automatic logic [id_bits-1:0] rr_next(input logic [id_bits-1:0] sel);
        if (int'(sel) == num_req - 1) return '0;
        return sel + id_bits'(1);
    endfunction

    logic [num_req-1:0][bank_bits-1:0]   req_bank;
    logic [num_req-1:0][row_bits-1:0]    req_row;
    logic [num_banks-1:0][num_req-1:0]   wr_gnt_vec;
    logic [num_banks-1:0][num_req-1:0]   rd_gnt_vec;
    logic [num_banks-1:0]                rd_vld_p2;
    logic [num_banks-1:0][id_bits-1:0]   rd_id_p2;

    logic [num_req-1:0]                  rsp_valid_d, rsp_valid_q;
    logic [num_req-1:0][bit_width-1:0]   rsp_data_d, rsp_data_q;

    always_comb begin
        for (int r = 0; r < num_req; r++) begin
            req_bank[r] = req_addr[r][bank_bits-1:0];
            req_row[r]  = req_addr[r][addr_bit_width-1:bank_bits];
        end
    end

    for (genvar b = 0; b < num_banks; b++) begin : g_bank
        logic [num_req-1:0]   wr_cand, rd_cand;
        logic                 wr_hit, rd_hit, rd_ok;
        logic                 wr_gnt, rd_gnt;
        logic [id_bits-1:0]   wr_sel, rd_sel;
        logic [id_bits-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;

        logic                 wr_en_p1_d, wr_en_p1_q;
        logic [row_bits-1:0]  wr_row_p1_d, wr_row_p1_q;
        logic [bit_width-1:0] wr_data_p1_d, wr_data_p1_q;
        logic                 rd_en_p1_d, rd_en_p1_q;
        logic [row_bits-1:0]  rd_row_p1_d, rd_row_p1_q;
        logic [id_bits-1:0]   rd_id_p1_d, rd_id_p1_q;
        logic                 rd_vld_p2_q;
        logic [id_bits-1:0]   rd_id_p2_q;

        always_comb begin
            wr_cand = '0;
            rd_cand = '0;
            for (int r = 0; r < num_req; r++) begin
                wr_cand[r] = req_valid[r] &  req_we[r] & (req_bank[r] == bank_bits'(b));
                rd_cand[r] = req_valid[r] & ~req_we[r] & (req_bank[r] == bank_bits'(b));
            end
        end

        always_comb begin
            wr_hit = 1'b0;
            wr_sel = '0;
            rd_hit = 1'b0;
            rd_sel = '0;
            for (int k = 0; k < num_req; k++) begin
                if (!wr_hit && wr_cand[rr_idx(wr_ptr_q, k)]) begin
                    wr_hit = 1'b1;
                    wr_sel = rr_idx(wr_ptr_q, k);
                end
                if (!rd_hit && rd_cand[rr_idx(rd_ptr_q, k)]) begin
                    rd_hit = 1'b1;
                    rd_sel = rr_idx(rd_ptr_q, k);
                end
            end
        end

        // A read colliding with this cycle's write row waits a cycle so it sees the new data.
        assign rd_ok  = rd_hit & ~(wr_hit & (req_row[rd_sel] == req_row[wr_sel]));
        assign wr_gnt = wr_hit & rst_n;
        assign rd_gnt = rd_ok & rst_n;

        assign wr_gnt_vec[b] = wr_gnt ? (num_req'(1) << wr_sel) : '0;
        assign rd_gnt_vec[b] = rd_gnt ? (num_req'(1) << rd_sel) : '0;

        always_comb begin
            wr_ptr_d     = wr_gnt ? rr_next(wr_sel) : wr_ptr_q;
            rd_ptr_d     = rd_gnt ? rr_next(rd_sel) : rd_ptr_q;
            wr_en_p1_d   = wr_gnt;
            wr_row_p1_d  = wr_gnt ? req_row[wr_sel]   : wr_row_p1_q;
            wr_data_p1_d = wr_gnt ? req_wdata[wr_sel] : wr_data_p1_q;
            rd_en_p1_d   = rd_gnt;
            rd_row_p1_d  = rd_gnt ? req_row[rd_sel] : rd_row_p1_q;
            rd_id_p1_d   = rd_gnt ? rd_sel          : rd_id_p1_q;
        end

        // Stage p1: bank command; stage p2: tag aligned with returning bank data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
                wr_en_p1_q   <= 1'b0;
                wr_row_p1_q  <= '0;
                wr_data_p1_q <= '0;
                rd_en_p1_q   <= 1'b0;
                rd_row_p1_q  <= '0;
                rd_id_p1_q   <= '0;
                rd_vld_p2_q  <= 1'b0;
                rd_id_p2_q   <= '0;
            end else begin
                wr_ptr_q     <= wr_ptr_d;
                rd_ptr_q     <= rd_ptr_d;
                wr_en_p1_q   <= wr_en_p1_d;
                wr_row_p1_q  <= wr_row_p1_d;
                wr_data_p1_q <= wr_data_p1_d;
                rd_en_p1_q   <= rd_en_p1_d;
                rd_row_p1_q  <= rd_row_p1_d;
                rd_id_p1_q   <= rd_id_p1_d;
                rd_vld_p2_q  <= rd_en_p1_q;
                rd_id_p2_q   <= rd_id_p1_q;
            end
        end

        assign mem_wr_en[b]   = wr_en_p1_q;
        assign mem_wr_addr[b] = wr_row_p1_q;
        assign mem_wr_data[b] = wr_data_p1_q;
        assign mem_rd_en[b]   = rd_en_p1_q;
        assign mem_rd_addr[b] = rd_row_p1_q;
        assign rd_vld_p2[b]   = rd_vld_p2_q;
        assign rd_id_p2[b]    = rd_id_p2_q;
    end

    always_comb begin
        req_ready = '0;
        for (int b = 0; b < num_banks; b++) begin
            req_ready = req_ready | wr_gnt_vec[b] | rd_gnt_vec[b];
        end
    end

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int b = 0; b < num_banks; b++) begin
            if (rd_vld_p2[b]) begin
                rsp_valid_d[rd_id_p2[b]] = 1'b1;
                rsp_data_d[rd_id_p2[b]]  = mem_rd_data[b];
            end
        end
    end

    // Stage p3: response register back to the issuing requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_memory_mb_arbiter.sv
// Bench for memory_mb_arbiter: behavioural bank memories, grant vector table,
// read-response scoreboard and hand-written reset/hazard sequences.
module tb_memory_mb_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_valid, req_we, req_ready, rsp_valid;
    logic [3:0][7:0]   req_addr;
    logic [3:0][31:0]  req_wdata, rsp_data;
    logic [3:0]        mem_wr_en, mem_rd_en;
    logic [3:0][5:0]   mem_wr_addr, mem_rd_addr;
    logic [3:0][31:0]  mem_wr_data, mem_rd_data;

    memory_mb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rsp_count = 0;

    function automatic logic [31:0] pat(input logic [7:0] a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Banks: synchronous write, registered read; unwritten words hold pat(flat address).
    logic [31:0] bank_mem [4][64];
    bit          bank_w   [4][64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < 4; b++) begin
            if (mem_wr_en[b]) begin
                bank_mem[b][mem_wr_addr[b]] <= mem_wr_data[b];
                bank_w[b][mem_wr_addr[b]]   <= 1'b1;
            end
            if (mem_rd_en[b])
                mem_rd_data[b] <= bank_w[b][mem_rd_addr[b]] ? bank_mem[b][mem_rd_addr[b]]
                                                            : pat({mem_rd_addr[b], 2'(b)});
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t        exp_q [4][$];
    logic [31:0] shadow   [256];
    bit          shadow_w [256];

    // Scoreboard: reads granted in cycle T must return the architectural value 3 cycles later.
    always @(negedge clk) begin
        for (int r = 0; r < 4; r++) if (rsp_valid[r]) rsp_count++;
        if (!rst_n) begin
            for (int r = 0; r < 4; r++) exp_q[r].delete();
        end else begin
            for (int r = 0; r < 4; r++) begin
                if (rsp_valid[r]) begin
                    total++;
                    if (exp_q[r].size() == 0) begin
                        bad++;
                        $display("FAIL rsp_unexpected r%0d: got data %h at cycle %0d, required no response", r, rsp_data[r], cyc);
                    end else begin
                        exp_t e;
                        e = exp_q[r].pop_front();
                        if (rsp_data[r] !== e.data || e.due != cyc) begin
                            bad++;
                            $display("FAIL rsp_data r%0d: got %h at cycle %0d, required %h at cycle %0d", r, rsp_data[r], cyc, e.data, e.due);
                        end
                    end
                end
                if (exp_q[r].size() != 0 && exp_q[r][0].due < cyc) begin
                    exp_t e;
                    e = exp_q[r].pop_front();
                    total++;
                    bad++;
                    $display("FAIL rsp_missing r%0d: got nothing by cycle %0d, required %h at cycle %0d", r, cyc, e.data, e.due);
                end
            end
            for (int r = 0; r < 4; r++) begin
                if (req_valid[r] && req_ready[r] && !req_we[r]) begin
                    exp_t e;
                    e.data = shadow_w[req_addr[r]] ? shadow[req_addr[r]] : pat(req_addr[r]);
                    e.due  = cyc + 3;
                    exp_q[r].push_back(e);
                end
            end
            for (int r = 0; r < 4; r++) begin
                if (req_valid[r] && req_ready[r] && req_we[r]) begin
                    shadow[req_addr[r]]   = req_wdata[r];
                    shadow_w[req_addr[r]] = 1'b1;
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  we;
        logic [7:0]  a [4];
        logic [31:0] d [4];
        logic [3:0]  rdy;
    } vec_t;
    vec_t vecs [11];

    task automatic set_vec(input int i, input logic [3:0] v, input logic [3:0] we,
                           input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] a3, input logic [31:0] dbase, input logic [3:0] rdy);
        vecs[i].v = v;
        vecs[i].we = we;
        vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2; vecs[i].a[3] = a3;
        for (int r = 0; r < 4; r++) vecs[i].d[r] = dbase + 32'(r);
        vecs[i].rdy = rdy;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic rq(input int r, input logic we, input logic [7:0] a, input logic [31:0] d);
        req_valid[r] = 1'b1;
        req_we[r]    = we;
        req_addr[r]  = a;
        req_wdata[r] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_we    = 4'h0;
        req_addr  = '0;
        req_wdata = '0;

        set_vec(0,  4'hF, 4'h0, 8'h02, 8'h06, 8'h0A, 8'h0E, 32'h0,         4'b0001);
        set_vec(1,  4'hF, 4'h0, 8'h02, 8'h06, 8'h0A, 8'h0E, 32'h0,         4'b0010);
        set_vec(2,  4'hF, 4'h0, 8'h02, 8'h06, 8'h0A, 8'h0E, 32'h0,         4'b0100);
        set_vec(3,  4'hF, 4'h0, 8'h02, 8'h06, 8'h0A, 8'h0E, 32'h0,         4'b1000);
        set_vec(4,  4'hF, 4'h0, 8'h02, 8'h06, 8'h0A, 8'h0E, 32'h0,         4'b0001);
        set_vec(5,  4'hF, 4'h0, 8'h00, 8'h01, 8'h02, 8'h03, 32'h0,         4'b1111);
        set_vec(6,  4'hF, 4'hF, 8'h10, 8'h11, 8'h12, 8'h13, 32'h6000_0000, 4'b1111);
        set_vec(7,  4'hF, 4'h0, 8'h10, 8'h11, 8'h12, 8'h13, 32'h0,         4'b1111);
        set_vec(8,  4'hF, 4'hF, 8'h03, 8'h07, 8'h0B, 8'h0F, 32'h8000_0000, 4'b0001);
        set_vec(9,  4'h7, 4'h1, 8'h17, 8'h1B, 8'h20, 8'h00, 32'h9000_0000, 4'b0111);
        set_vec(10, 4'h0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0,         4'b0000);

        // Reset held with every requester asking.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_mem_addr", {mem_wr_addr, mem_rd_addr}, 0);
        nxt();
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            for (int r = 0; r < 4; r++) begin
                req_valid[r] = vecs[i].v[r];
                req_we[r]    = vecs[i].we[r];
                req_addr[r]  = vecs[i].a[r];
                req_wdata[r] = vecs[i].d[r];
            end
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), req_ready, vecs[i].rdy);
            nxt();
        end
        idle_in();
        repeat (5) nxt();

        // Single write then read of 0x05 (bank 1, row 1).
        rq(0, 1'b1, 8'h05, 32'hDEADBEEF);
        @(negedge clk); chk("wr05_ready", req_ready, 4'b0001); nxt();
        idle_in();
        @(negedge clk);
        chk("wr05_wr_en", mem_wr_en, 4'b0010);
        chk("wr05_wr_row", mem_wr_addr[1], 6'd1);
        chk("wr05_wr_data", mem_wr_data[1], 32'hDEADBEEF);
        chk("wr05_rd_en", mem_rd_en, 4'b0000);
        nxt();
        rq(0, 1'b0, 8'h05, 32'h0);
        @(negedge clk); chk("rd05_ready", req_ready, 4'b0001); nxt();
        idle_in();
        @(negedge clk);
        chk("rd05_rd_en", mem_rd_en, 4'b0010);
        chk("rd05_rd_row", mem_rd_addr[1], 6'd1);
        nxt();
        @(negedge clk); chk("rd05_early", rsp_valid, 4'b0000); nxt();
        @(negedge clk);
        chk("rd05_rsp_valid", rsp_valid, 4'b0001);
        chk("rd05_rsp_data", rsp_data[0], 32'hDEADBEEF);
        nxt();

        // Same-address write/read collision on 0x0A.
        rq(0, 1'b1, 8'h0A, 32'h0000_1234);
        rq(1, 1'b0, 8'h0A, 32'h0);
        @(negedge clk); chk("haz_ready_t0", req_ready, 4'b0001); nxt();
        idle_in();
        rq(1, 1'b0, 8'h0A, 32'h0);
        @(negedge clk);
        chk("haz_ready_t1", req_ready, 4'b0010);
        chk("haz_wr_en_t1", mem_wr_en, 4'b0100);
        nxt();
        idle_in();
        repeat (2) nxt();
        @(negedge clk);
        chk("haz_rsp_valid", rsp_valid, 4'b0010);
        chk("haz_rsp_data", rsp_data[1], 32'h0000_1234);
        nxt();
        repeat (3) nxt();

        // Reset one cycle after a read grant discards the read.
        rq(2, 1'b0, 8'h01, 32'h0);
        @(negedge clk); chk("rstmid_ready", req_ready, 4'b0100); nxt();
        rst_n = 1'b0;
        idle_in();
        @(negedge clk);
        chk("rstmid_rd_en", mem_rd_en, 4'b0000);
        chk("rstmid_rsp_valid", rsp_valid, 4'b0000);
        begin
            int snap;
            snap = rsp_count;
            repeat (2) nxt();
            rst_n = 1'b1;
            repeat (6) nxt();
            chk("rstmid_no_rsp", 128'(rsp_count - snap), 0);
        end

        // Pointers restart at requester 0 after reset.
        for (int r = 0; r < 4; r++) rq(r, 1'b0, 8'(r * 4), 32'h0);
        @(negedge clk); chk("post_rst_ready", req_ready, 4'b0001); nxt();
        idle_in();
        repeat (6) nxt();

        for (int r = 0; r < 4; r++)
            chk($sformatf("drain_q%0d", r), 128'(exp_q[r].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
